roi_shr_master: RTL and testbench

Host-side driver for the timing-fuzzer serial harness: takes a parallel stimulus word, serializes it onto the harness `di` line, pulses `stb` to load the ROI and capture its outputs, then deserializes the harness `do` line back into a parallel response word. It sits in the same clock domain as the harness `top` and connects directly to its `di`/`stb`/`do` pins. This lets on-chip sequencers and benches run ROI transactions without hand-driving serial bits.

---
 rtl/roi_shr_pkg.sv | 22 ++
 rtl/roi_shr_bitcnt.sv | 36 +++
 rtl/roi_shr_master.sv | 165 ++++++++++++++++
 tb/tb_roi_shr_master.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_shr_pkg.sv
// Shared types and sizing helpers for the ROI serial-harness master.
package roi_shr_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT_IN  = 2'd1,
      STROBE    = 2'd2,
      SHIFT_OUT = 2'd3
   } roi_shr_state_e;

   // Counter must hold the longer of the two phase lengths without wrapping.
   function automatic int cnt_width(input int din_n, input int dout_n);
      int m;
      m = (din_n > dout_n) ? din_n : dout_n;
      return $clog2(m + 1);
   endfunction

   function automatic int max1(input int n);
      return (n > 1) ? n : 1;
   endfunction

endpackage

// File: rtl/roi_shr_bitcnt.sv
// Loadable down-counter shared by the shift-in and shift-out phases; saturates at zero.
module roi_shr_bitcnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] len,
   input  logic         dec,
   output logic         zero,
   output logic         last
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = len;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);
   assign last = (cnt_q == W'(1));

endmodule

// File: rtl/roi_shr_master.sv
// Serializes a stimulus word into the harness, strobes it, and deserializes the response.
// Define ROI_SHR_TWO_PASS_EN to shift the word twice so the response matches the current word.
module roi_shr_master
   import roi_shr_pkg::*;
#(
   parameter int DIN_N  = 8,
   parameter int DOUT_N = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [((DIN_N > 0) ? DIN_N : 1)-1:0]  din_word,
   output logic                                  busy,
   output logic                                  done,
   output logic [DOUT_N-1:0]                     dout_word,
   output logic                                  di,
   output logic                                  stb,
   input  logic                                  sdo,
   output roi_shr_state_e                        state_o
);

   localparam int DI_W = max1(DIN_N);
   localparam int CW   = cnt_width(DIN_N, DOUT_N);

   // Handshake: start is a level sampled only while IDLE; done is a one-cycle
   // pulse and dout_word holds its value until the next done.
   roi_shr_state_e    state_q, state_d;
   logic [DI_W-1:0]   shreg_q, shreg_d;
   logic [DOUT_N-1:0] cap_q, cap_d;
   logic [DOUT_N-1:0] dout_q, dout_d;
   logic              di_q, di_d;
   logic              stb_q, stb_d;
   logic              done_q, done_d;
   logic              cnt_load, cnt_dec, cnt_zero, cnt_last;
   logic [CW-1:0]     cnt_len;
`ifdef ROI_SHR_TWO_PASS_EN
   logic              pass_q, pass_d;
`endif

   roi_shr_bitcnt #(.W(CW)) u_bitcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .len   (cnt_len),
      .dec   (cnt_dec),
      .zero  (cnt_zero),
      .last  (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_len  = '0;
      cnt_dec  = 1'b0;
`ifdef ROI_SHR_TWO_PASS_EN
      pass_d   = pass_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef ROI_SHR_TWO_PASS_EN
               pass_d = 1'b0;
`endif
               if (DIN_N > 0) begin
                  state_d  = SHIFT_IN;
                  cnt_load = 1'b1;
                  cnt_len  = CW'(DIN_N);
               end else begin
                  state_d  = STROBE;
               end
            end
         end
         SHIFT_IN: begin
            cnt_dec = 1'b1;
            if (cnt_last || cnt_zero) state_d = STROBE;
         end
         STROBE: begin
            state_d  = SHIFT_OUT;
            cnt_load = 1'b1;
            cnt_len  = CW'(DOUT_N);
`ifdef ROI_SHR_TWO_PASS_EN
            // First strobe only primes the harness din; its capture is dropped.
            if (!pass_q) begin
               pass_d = 1'b1;
               if (DIN_N > 0) begin
                  state_d = SHIFT_IN;
                  cnt_len = CW'(DIN_N);
               end else begin
                  state_d  = STROBE;
                  cnt_load = 1'b0;
               end
            end
`endif
         end
         SHIFT_OUT: begin
            cnt_dec = 1'b1;
            if (cnt_last || cnt_zero) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed for the next cycle so di/stb/done leave flops.
   always_comb begin
      shreg_d = shreg_q;
      cap_d   = cap_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      if (state_q == IDLE && start) begin
         shreg_d = din_word;
      end else if (state_q == SHIFT_IN) begin
         // Rotate rather than shift so a second pass finds the word intact.
         shreg_d = (shreg_q << 1) | (shreg_q >> (DI_W - 1));
      end
      if (state_q == SHIFT_OUT) begin
         cap_d = (cap_q << 1) | DOUT_N'(sdo);
         if (cnt_last || cnt_zero) begin
            dout_d = cap_d;
            done_d = 1'b1;
         end
      end
      di_d  = (state_d == SHIFT_IN) ? shreg_d[DI_W-1] : 1'b0;
      stb_d = (state_d == STROBE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cap_q   <= '0;
         dout_q  <= '0;
         di_q    <= 1'b0;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef ROI_SHR_TWO_PASS_EN
         pass_q  <= 1'b0;
`endif
      end else begin
         shreg_q <= shreg_d;
         cap_q   <= cap_d;
         dout_q  <= dout_d;
         di_q    <= di_d;
         stb_q   <= stb_d;
         done_q  <= done_d;
`ifdef ROI_SHR_TWO_PASS_EN
         pass_q  <= pass_d;
`endif
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign dout_word = dout_q;
   assign di        = di_q;
   assign stb       = stb_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_roi_shr_master.sv
// Directed bench for roi_shr_master against a harness model whose ROI is dout = ~din.
module tb_roi_shr_master;
   import roi_shr_pkg::*;

`ifdef ROI_SHR_TWO_PASS_EN
   localparam int          E_LAT    = 27;
   localparam logic [7:0]  E_A5     = 8'h5A;
   localparam logic [7:0]  E_3C     = 8'hC3;
   localparam logic [7:0]  E_80     = 8'h7F;
   localparam logic [7:0]  E_11     = 8'hEE;
   localparam logic [7:0]  E_00A    = 8'hFF;
   localparam logic [7:0]  E_69     = 8'h96;
   localparam logic [7:0]  E_00B    = 8'hFF;
   localparam logic [31:0] E_DI_A5  = 32'h0002_954A;
   localparam logic [31:0] E_DI_80  = 32'h0000_0402;
   localparam logic [31:0] E_STB    = 32'h0004_0200;
   localparam logic [31:0] E_BUSY   = 32'h07FF_FFFE;
   localparam int          E2_LAT   = 7;
   localparam int          E2_FS    = 3;
   localparam logic [31:0] E2_STB   = 32'h0000_0006;
`else
   localparam int          E_LAT    = 18;
   localparam logic [7:0]  E_A5     = 8'hFF;
   localparam logic [7:0]  E_3C     = 8'h5A;
   localparam logic [7:0]  E_80     = 8'hC3;
   localparam logic [7:0]  E_11     = 8'h7F;
   localparam logic [7:0]  E_00A    = 8'hEE;
   localparam logic [7:0]  E_69     = 8'hFF;
   localparam logic [7:0]  E_00B    = 8'h96;
   localparam logic [31:0] E_DI_A5  = 32'h0000_014A;
   localparam logic [31:0] E_DI_80  = 32'h0000_0002;
   localparam logic [31:0] E_STB    = 32'h0000_0200;
   localparam logic [31:0] E_BUSY   = 32'h0003_FFFE;
   localparam int          E2_LAT   = 6;
   localparam int          E2_FS    = 2;
   localparam logic [31:0] E2_STB   = 32'h0000_0002;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [7:0] din_word = 8'h00;
   logic busy, done, di, stb, sdo;
   logic [7:0] dout_word;
   roi_shr_state_e st1;

   logic start2 = 1'b0;
   logic [0:0] din_word2 = 1'b0;
   logic busy2, done2, di2, stb2;
   logic sdo2 = 1'b0;
   logic [3:0] dout_word2;
   roi_shr_state_e st2;

   int n_vec = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   roi_shr_master #(.DIN_N(8), .DOUT_N(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .din_word(din_word),
      .busy(busy), .done(done), .dout_word(dout_word),
      .di(di), .stb(stb), .sdo(sdo), .state_o(st1)
   );

   roi_shr_master #(.DIN_N(0), .DOUT_N(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .din_word(din_word2),
      .busy(busy2), .done(done2), .dout_word(dout_word2),
      .di(di2), .stb(stb2), .sdo(sdo2), .state_o(st2)
   );

   // Harness model: shift on every edge, load din and capture ~din on stb.
   logic [7:0] h_din = 8'h00;
   logic [7:0] h_din_shr = 8'h00;
   logic [7:0] h_dout_shr = 8'h00;
   always @(posedge clk) begin
      if (stb) begin
         h_din      <= h_din_shr;
         h_dout_shr <= ~h_din;
      end else begin
         h_din_shr  <= {h_din_shr[6:0], di};
         h_dout_shr <= {h_dout_shr[6:0], 1'b0};
      end
   end
   assign sdo = h_dout_shr[7];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [7:0] w);
      @(negedge clk);
      start    = 1'b1;
      din_word = w;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Follows one transaction from just after its accepting edge; returns at the done negedge.
   task automatic track(input int inject_cyc, output int done_cyc,
                        output logic [31:0] di_h, output logic [31:0] stb_h,
                        output logic [31:0] busy_h);
      done_cyc = -1;
      di_h = '0;
      stb_h = '0;
      busy_h = '0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == inject_cyc) begin
            start    = 1'b1;
            din_word = 8'h22;
         end else begin
            start = 1'b0;
         end
         if (c < 32) begin
            di_h[c]   = di;
            stb_h[c]  = stb;
            busy_h[c] = busy;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
      end
   endtask

   int          dc;
   int          extra;
   logic [31:0] dh, sh, bh;
   logic [3:0]  pat;

   initial begin
      // Reset state
      #12;
      chk("rst_di", di, 0);
      chk("rst_stb", stb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dout", dout_word, 0);
      chk("rst_dout2", dout_word2, 0);
      @(negedge clk);
      rst_n = 1'b1;

      launch(8'hA5);
      track(0, dc, dh, sh, bh);
      chk("a5_lat", dc, E_LAT);
      chk("a5_dout", dout_word, E_A5);
      chk("a5_di_bits", dh, E_DI_A5);
      chk("a5_stb", sh, E_STB);

      launch(8'h3C);
      track(0, dc, dh, sh, bh);
      chk("3c_dout", dout_word, E_3C);

      launch(8'h80);
      track(0, dc, dh, sh, bh);
      chk("80_lat", dc, E_LAT);
      chk("80_dout", dout_word, E_80);
      chk("80_di_bits", dh, E_DI_80);
      chk("80_stb", sh, E_STB);

      // Back-to-back start in the done cycle, plus an ignored start while busy
      start    = 1'b1;
      din_word = 8'h11;
      @(posedge clk);
      #1 start = 1'b0;
      track(3, dc, dh, sh, bh);
      chk("b2b_busy_c1", bh[1], 1);
      chk("b2b_busy_mask", bh, E_BUSY);
      chk("b2b_lat", dc, E_LAT);
      chk("b2b_dout", dout_word, E_11);
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("no_extra_done", extra, 0);

      launch(8'h00);
      track(0, dc, dh, sh, bh);
      chk("00_dout", dout_word, E_00A);

      // Asynchronous reset in cycle 5 of a transaction
      launch(8'h5A);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_di", di, 0);
      chk("mid_rst_stb", stb, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_dout", dout_word, 0);
      @(negedge clk);
      rst_n = 1'b1;

      launch(8'h69);
      track(0, dc, dh, sh, bh);
      chk("post_rst_lat", dc, E_LAT);
      chk("post_rst_dout", dout_word, E_69);
      launch(8'h00);
      track(0, dc, dh, sh, bh);
      chk("post_rst_dout2", dout_word, E_00B);

      // DIN_N=0, DOUT_N=4 with do forced to 1,0,1,1
      pat = 4'b1011;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      dc = -1;
      sh = '0;
      for (int c = 1; c <= 20; c++) begin
         sdo2 = (c >= E2_FS && c < E2_FS + 4) ? pat[3 - (c - E2_FS)] : 1'b0;
         @(negedge clk);
         sh[c] = stb2;
         if (done2) begin
            dc = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("d0_stb", sh, E2_STB);
      chk("d0_lat", dc, E2_LAT);
      chk("d0_dout", dout_word2, 4'b1011);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
